// File: rtl/axi3_rd_arbiter.sv
// N:1 AXI3 read-channel arbiter: round-robin AR merge through a one-entry output
// register, ARID tagging with the master index, and RID-based R routing.
module axi3_rd_arbiter #(
    parameter int NUM_MASTERS     = 3,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        s_ar_valid,
    output logic [NUM_MASTERS-1:0]        s_ar_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_ar_addr,
    input  logic [NUM_MASTERS*8-1:0]      s_ar_len,
    input  logic [NUM_MASTERS*3-1:0]      s_ar_size,
    input  logic [NUM_MASTERS*2-1:0]      s_ar_burst,
    output logic [NUM_MASTERS-1:0]        s_r_valid,
    input  logic [NUM_MASTERS-1:0]        s_r_ready,
    output logic [DATA_WIDTH-1:0]         s_r_data,
    output logic [1:0]                    s_r_resp,
    output logic                          s_r_last,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ID_WIDTH-1:0]           m_arid,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic [1:0]                    m_arlock,
    output logic [3:0]                    m_arcache,
    output logic [2:0]                    m_arprot,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [ID_WIDTH-1:0]           m_rid,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    output logic                          err_bad_rid,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic                   r_arvalid;
    logic [ID_WIDTH-1:0]    r_arid;
    logic [ADDR_WIDTH-1:0]  r_araddr;
    logic [7:0]             r_arlen;
    logic [2:0]             r_arsize;
    logic [1:0]             r_arburst;
    logic [PTR_W-1:0]       r_ptr;
    logic                   r_err;

    logic                   w_slot_free;
    logic                   w_accept;
    logic                   w_grant_valid;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [PTR_W-1:0]       w_ptr_next;
    logic [NUM_MASTERS-1:0] w_eligible;
    logic [NUM_MASTERS-1:0] w_inc;
    logic [NUM_MASTERS-1:0] w_dec;
    logic [NUM_MASTERS-1:0] w_cnt_nz;
    logic [NUM_MASTERS-1:0] w_rid_hit;
    logic                   w_rid_ok;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [7:0]             w_sel_len;
    logic [2:0]             w_sel_size;
    logic [1:0]             w_sel_burst;

    assign w_slot_free = !r_arvalid || m_arready;
    assign w_accept    = w_slot_free && w_grant_valid;
    assign w_ptr_next  = (w_grant_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : w_grant_idx + PTR_W'(1);

    // Round-robin search starting at the pointer, wrapping past the last master.
    always_comb begin
        int j;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            j = ((int'(r_ptr) + k) >= NUM_MASTERS) ? (int'(r_ptr) + k - NUM_MASTERS) : (int'(r_ptr) + k);
            w_grant_idx   = (!w_grant_valid && w_eligible[j]) ? PTR_W'(j) : w_grant_idx;
            w_grant_valid = w_grant_valid | w_eligible[j];
        end
    end

    // Payload mux for the winning master.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_len   = '0;
        w_sel_size  = '0;
        w_sel_burst = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_sel_addr  = (w_grant_idx == PTR_W'(i)) ? s_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : w_sel_addr;
            w_sel_len   = (w_grant_idx == PTR_W'(i)) ? s_ar_len[i*8 +: 8]     : w_sel_len;
            w_sel_size  = (w_grant_idx == PTR_W'(i)) ? s_ar_size[i*3 +: 3]    : w_sel_size;
            w_sel_burst = (w_grant_idx == PTR_W'(i)) ? s_ar_burst[i*2 +: 2]   : w_sel_burst;
        end
    end

    // AR output slice and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_ptr     <= '0;
        end else if (w_accept) begin
            r_arvalid <= 1'b1;
            r_arid    <= ID_WIDTH'(w_grant_idx);
            r_araddr  <= w_sel_addr;
            r_arlen   <= w_sel_len;
            r_arsize  <= w_sel_size;
            r_arburst <= w_sel_burst;
            r_ptr     <= w_ptr_next;
        end else if (m_arready) begin
            r_arvalid <= 1'b0;
        end else begin
            r_arvalid <= r_arvalid;
        end
    end

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_master
        logic [CNT_W-1:0] r_cnt;

        assign w_eligible[g] = s_ar_valid[g] && (r_cnt != CNT_W'(MAX_OUTSTANDING));
        assign w_inc[g]      = w_accept && (w_grant_idx == PTR_W'(g));
        assign w_rid_hit[g]  = (m_rid == ID_WIDTH'(g));
        assign w_dec[g]      = m_rvalid && m_rready && m_rlast && w_rid_hit[g];
        assign w_cnt_nz[g]   = (r_cnt != '0);
        assign s_ar_ready[g] = w_inc[g];

        // Outstanding counter; a stray last beat at zero is ignored.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (w_inc[g] && !w_dec[g]) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec[g] && !w_inc[g] && w_cnt_nz[g]) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Beats carrying an unknown RID are swallowed so the slave never stalls.
    assign w_rid_ok  = |w_rid_hit;
    assign s_r_valid = {NUM_MASTERS{m_rvalid}} & w_rid_hit;
    assign m_rready  = !w_rid_ok || |(w_rid_hit & s_r_ready);
    assign s_r_data  = m_rdata;
    assign s_r_resp  = m_rresp;
    assign s_r_last  = m_rlast;

    // Sticky bad-RID flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (m_rvalid && !w_rid_ok) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign m_arvalid   = r_arvalid;
    assign m_arid      = r_arid;
    assign m_araddr    = r_araddr;
    assign m_arlen     = r_arlen;
    assign m_arsize    = r_arsize;
    assign m_arburst   = r_arburst;
    assign m_arlock    = 2'b00;
    assign m_arcache   = 4'b0000;
    assign m_arprot    = 3'b000;
    assign err_bad_rid = r_err;
    assign busy        = r_arvalid || (|w_cnt_nz);

endmodule
